// File: rtl/spi_slave_rx.sv
// ============================================================================
//  Module      : spi_slave_rx
//  Description : SPI slave endpoint. Oversamples SCLK/MOSI/LOAD in the clk
//                domain, deserialises each M-bit MSB-first frame into a
//                parallel word with a one-cycle valid pulse, flags frames
//                whose bit count differs from M, and returns a word on MISO.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    M            frame width in bits (2..255)
//    SYNC_STAGES  synchroniser depth for SCLK/MOSI/LOAD (>=2)
//  Ports
//    clk        system clock, rising edge
//    clr        asynchronous active-high reset
//    SCLK       serial clock from master (asynchronous)
//    MOSI       serial data from master
//    LOAD       frame strobe: high = idle, low = frame active
//    MISO       serial data to master
//    tx_dat     word returned on MISO in the next frame
//    tx_wr      one-cycle write strobe for tx_dat
//    tx_busy    high while a frame is active
//    rx_dat     last correctly received word
//    rx_valid   one-cycle pulse: rx_dat updated
//    frame_err  one-cycle pulse: frame ended with bit count != M
//    bit_cnt    bits received in the current frame (saturates at M+1)
//  Build option
//    SPI_SLV_ECHO_EN  when defined, a frame start with no tx_wr since the
//                     previous frame start returns the last good rx word.
// ============================================================================
`default_nettype none

module spi_slave_rx #(
    parameter int M           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         SCLK,
    input  logic         MOSI,
    input  logic         LOAD,
    output logic         MISO,
    input  logic [M-1:0] tx_dat,
    input  logic         tx_wr,
    output logic         tx_busy,
    output logic [M-1:0] rx_dat,
    output logic         rx_valid,
    output logic         frame_err,
    output logic [7:0]   bit_cnt
);

    // Counter is one bit wider than the port so that M+1 stays representable
    // when M = 255; the port value clamps at 255 in that corner.
    localparam logic [8:0] CNT_SAT = 9'(M + 1);
    localparam logic [8:0] CNT_M   = 9'(M);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Input synchronisers plus one edge-detect flop for SCLK and LOAD.
    // MOSI goes through the same depth so it stays aligned with SCLK.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_sclk_d;
    logic                   r_load_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_load_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_load_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], LOAD};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_load_d    <= r_load_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk;
    logic w_mosi;
    logic w_load;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_load_rise;
    logic w_load_fall;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_load      = r_load_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk &  r_sclk_d;
    assign w_load_rise =  w_load & ~r_load_d;
    assign w_load_fall = ~w_load &  r_load_d;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [M-1:0] r_tx_hold;
    logic [M-1:0] r_tx_sr;
    logic [M-1:0] r_rx_sr;
    logic [M-1:0] r_rx_dat;
    logic         r_rx_valid;
    logic         r_frame_err;
    logic [8:0]   r_cnt;

    logic         w_start;
    logic [M-1:0] w_tx_load;

    assign w_start = (r_state == IDLE) && w_load_fall;

`ifdef SPI_SLV_ECHO_EN
    // Tracks whether tx_wr was seen since the last frame start. A write in
    // the start cycle itself counts towards the following frame.
    logic r_wr_pend;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_pend <= 1'b0;
        end else if (w_start) begin
            r_wr_pend <= tx_wr;
        end else if (tx_wr) begin
            r_wr_pend <= 1'b1;
        end
    end

    assign w_tx_load = r_wr_pend ? r_tx_hold : r_rx_dat;
`else
    assign w_tx_load = r_tx_hold;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        tx_busy     = 1'b0;
        MISO        = 1'b0;
        case (r_state)
            // Wait for the line to be idle so a frame already running when
            // reset was released is never partially captured.
            WAIT_IDLE: begin
                if (w_load) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_load_fall) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                tx_busy = 1'b1;
                MISO    = r_tx_sr[M-1];
                if (w_load_rise) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                tx_busy     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = WAIT_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers, bit counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_tx_hold   <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_rx_dat    <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            // Last write wins; the start cycle reads the previous value
            // because of non-blocking update ordering.
            if (tx_wr) begin
                r_tx_hold <= tx_dat;
            end

            if (w_start) begin
                r_cnt   <= '0;
                r_rx_sr <= '0;
                r_tx_sr <= w_tx_load;
            end

            if (r_state == SHIFT) begin
                if (w_sclk_rise) begin
                    r_rx_sr <= {r_rx_sr[M-2:0], w_mosi};
                    if (r_cnt != CNT_SAT) begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                if (w_sclk_fall) begin
                    r_tx_sr <= {r_tx_sr[M-2:0], 1'b0};
                end
            end

            if (r_state == DONE) begin
                if (r_cnt == CNT_M) begin
                    r_rx_dat   <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign rx_dat    = r_rx_dat;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign bit_cnt   = r_cnt[8] ? 8'hFF : r_cnt[7:0];

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
// ============================================================================
//  Module      : tb_spi_slave_rx
//  Description : Self-checking bench for spi_slave_rx. A master task drives
//                directed frames and queues the expected result; a monitor
//                pops and compares whenever rx_valid or frame_err fires.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_rx;

    localparam int M = 16;
    localparam int S = 2;
    localparam int H = 6;   // SCLK half period in clk cycles

    logic         clk = 1'b0;
    logic         clr;
    logic         SCLK;
    logic         MOSI;
    logic         LOAD;
    logic         MISO;
    logic [M-1:0] tx_dat;
    logic         tx_wr;
    logic         tx_busy;
    logic [M-1:0] rx_dat;
    logic         rx_valid;
    logic         frame_err;
    logic [7:0]   bit_cnt;

    spi_slave_rx #(.M(M), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .clr       (clr),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .LOAD      (LOAD),
        .MISO      (MISO),
        .tx_dat    (tx_dat),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .rx_dat    (rx_dat),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_err;
        logic [15:0] dat;
        logic [7:0]  cnt;
        logic [31:0] miso_exp;
        logic [31:0] miso_got;
        int          t_load;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every output event consumes one queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!clr && (rx_valid || frame_err)) begin
            chk("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_event", 32'({rx_valid, frame_err}), 32'd0);
            end else begin
                e = q.pop_front();
                chk("frame_err", 32'(frame_err), 32'(e.is_err));
                chk("rx_valid", 32'(rx_valid), 32'(!e.is_err));
                chk("rx_dat", 32'(rx_dat), 32'(e.dat));
                chk("bit_cnt", 32'(bit_cnt), 32'(e.cnt));
                chk("latency", 32'(cyc - e.t_load), 32'(S + 2));
                chk("miso_word", e.miso_got, e.miso_exp);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [15:0] d);
        @(negedge clk);
        tx_dat = d;
        tx_wr  = 1'b1;
        @(negedge clk);
        tx_wr  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_dat"},    32'(rx_dat),    32'd0);
        chk({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_bit_cnt"},   32'(bit_cnt),   32'd0);
        chk({tag, "_miso"},      32'(MISO),      32'd0);
        chk({tag, "_tx_busy"},   32'(tx_busy),   32'd0);
    endtask

    // n bits MSB-first from mosi_bits[n-1:0]; tx_word is the word expected on
    // MISO; wr_bit/clr_bit inject a tx_wr or a clr pulse before that bit.
    task automatic frame(input int n, input logic [31:0] mosi_bits,
                         input logic [15:0] tx_word, input int wr_bit,
                         input logic [15:0] wr_dat, input int clr_bit,
                         input logic [15:0] exp_dat);
        logic [31:0] got;
        logic [31:0] w;
        exp_t        e;
        got = '0;
        @(negedge clk);
        LOAD = 1'b0;
        wait_clk(H);
        for (int i = 0; i < n; i++) begin
            if (i == clr_bit) begin
                clr = 1'b1;
                #1;
                check_reset_outputs("clr_mid");
                @(negedge clk);
                clr = 1'b0;
            end
            if (i == wr_bit) begin
                tx_dat = wr_dat;
                tx_wr  = 1'b1;
                @(negedge clk);
                tx_wr  = 1'b0;
            end
            MOSI = mosi_bits[n-1-i];
            wait_clk(H);
            got  = {got[30:0], MISO};
            SCLK = 1'b1;
            wait_clk(H);
            SCLK = 1'b0;
        end
        wait_clk(H);
        LOAD = 1'b1;
        if (clr_bit < 0) begin
            w          = {16'h0, tx_word};
            e.is_err   = (n != M);
            e.dat      = exp_dat;
            e.cnt      = (n > M) ? 8'(M + 1) : 8'(n);
            e.miso_exp = (n <= M) ? (w >> (M - n)) : (w << (n - M));
            e.miso_got = got;
            e.t_load   = cyc;
            q.push_back(e);
            for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
            if (q.size() != 0) begin
                chk("event_timeout", 32'(q.size()), 32'd0);
                q.delete();
            end
        end else begin
            wait_clk(20);
        end
        wait_clk(4);
    endtask

`ifdef SPI_SLV_ECHO_EN
    localparam logic ECHO = 1'b1;
`else
    localparam logic ECHO = 1'b0;
`endif

    initial begin
        clr    = 1'b1;
        SCLK   = 1'b0;
        MOSI   = 1'b0;
        LOAD   = 1'b1;
        tx_dat = '0;
        tx_wr  = 1'b0;
        wait_clk(3);
        check_reset_outputs("in_reset");
        clr = 1'b0;
        wait_clk(10);
        check_reset_outputs("after_reset");

        tx_write(16'hA5C3);
        // Good frame: receive 1234, send A5C3.
        frame(16, 32'h1234, 16'hA5C3, -1, 16'h0, -1, 16'h1234);
        // Short frame: 12 bits, error, rx_dat unchanged.
        frame(12, 32'hABC, ECHO ? 16'h1234 : 16'hA5C3, -1, 16'h0, -1, 16'h1234);
        // Long frame: 17 bits, count saturates at 17.
        frame(17, 32'h1FFFF, ECHO ? 16'h1234 : 16'hA5C3, -1, 16'h0, -1, 16'h1234);
        // tx_wr mid-frame: current frame keeps old word.
        frame(16, 32'h5A5A, ECHO ? 16'h1234 : 16'hA5C3, 8, 16'h00FF, -1, 16'h5A5A);
        // Next frame sends the word written mid-frame.
        frame(16, 32'h0F0F, 16'h00FF, -1, 16'h0, -1, 16'h0F0F);
        // clr before bit 7: no event from the remainder of this frame.
        frame(16, 32'hFFFF, 16'h0000, -1, 16'h0, 7, 16'h0000);
        // Recovery: everything was cleared, so MISO returns zero.
        frame(16, 32'hC3A5, 16'h0000, -1, 16'h0, -1, 16'hC3A5);
        tx_write(16'h1111);
        frame(16, 32'hBEEF, 16'h1111, -1, 16'h0, -1, 16'hBEEF);
        // Echo build returns BEEF; otherwise tx_hold repeats.
        frame(16, 32'h0000, ECHO ? 16'hBEEF : 16'h1111, -1, 16'h0, -1, 16'h0000);
        // Zero-bit frame still flags an error.
        frame(0, 32'h0, ECHO ? 16'h0000 : 16'h1111, -1, 16'h0, -1, 16'h0000);

        chk("bit_cnt_hold", 32'(bit_cnt), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
